// File: rtl/pipe_ir_ctrl.sv
// pipe_ir_ctrl: D/E/M/W instruction and PC pipeline registers with stall bubbles,
// stall/retire statistics and a consecutive-stall watchdog.
module pipe_ir_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int MAX_STALL = 2,
  parameter logic [WIDTH-1:0] PC_RST = 32'h00003000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic [WIDTH-1:0] instr_f,
  input  logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] IR_D,
  output logic [WIDTH-1:0] IR_E,
  output logic [WIDTH-1:0] IR_M,
  output logic [WIDTH-1:0] IR_W,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PC_E,
  output logic [WIDTH-1:0] PC_M,
  output logic [WIDTH-1:0] PC_W,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             stall_err
);
  localparam int RW = $clog2(MAX_STALL + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL + 1);
  localparam logic [RW-1:0] RUN_LIM = RW'(MAX_STALL);

  logic [WIDTH-1:0] pc_f_q, pc_f_d, ir_d_q, ir_d_d, pc_d_q, pc_d_d;
  logic [WIDTH-1:0] ir_e_q, ir_e_d, pc_e_q, pc_e_d, ir_m_q, pc_m_q, ir_w_q, pc_w_q;
  logic [CNT_W-1:0] stall_q, stall_d, retire_q, retire_d;
  logic [RW-1:0]    run_q, run_d;
  logic             err_q, err_d;

  // A stall freezes fetch and decode and drops a zero word (sll $0) into execute.
  always_comb begin
    pc_f_d   = stop ? pc_f_q : npc;
    ir_d_d   = stop ? ir_d_q : instr_f;
    pc_d_d   = stop ? pc_d_q : pc_f_q;
    ir_e_d   = stop ? '0 : ir_d_q;
    pc_e_d   = stop ? '0 : pc_d_q;
    stall_d  = (stop && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    retire_d = (ir_m_q != '0 && retire_q != '1) ? retire_q + 1'b1 : retire_q;
    run_d    = !stop ? '0 : (run_q == RUN_MAX ? run_q : run_q + 1'b1);
    err_d    = err_q | (stop && run_q >= RUN_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f_q   <= PC_RST;
      ir_d_q   <= '0;
      pc_d_q   <= '0;
      ir_e_q   <= '0;
      pc_e_q   <= '0;
      ir_m_q   <= '0;
      pc_m_q   <= '0;
      ir_w_q   <= '0;
      pc_w_q   <= '0;
      stall_q  <= '0;
      retire_q <= '0;
      run_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_f_q   <= pc_f_d;
      ir_d_q   <= ir_d_d;
      pc_d_q   <= pc_d_d;
      ir_e_q   <= ir_e_d;
      pc_e_q   <= pc_e_d;
      ir_m_q   <= ir_e_q;
      pc_m_q   <= pc_e_q;
      ir_w_q   <= ir_m_q;
      pc_w_q   <= pc_m_q;
      stall_q  <= stall_d;
      retire_q <= retire_d;
      run_q    <= run_d;
      err_q    <= err_d;
    end
  end

  assign pc_f       = pc_f_q;
  assign IR_D       = ir_d_q;
  assign IR_E       = ir_e_q;
  assign IR_M       = ir_m_q;
  assign IR_W       = ir_w_q;
  assign PC_D       = pc_d_q;
  assign PC_E       = pc_e_q;
  assign PC_M       = pc_m_q;
  assign PC_W       = pc_w_q;
  assign stall_cnt  = stall_q;
  assign retire_cnt = retire_q;
  assign stall_err  = err_q;
endmodule

// File: tb/tb_pipe_ir_ctrl.sv
// tb_pipe_ir_ctrl: directed checks of pipeline advance, stall bubbles, watchdog,
// async reset and counter saturation (CNT_W=4).
module tb_pipe_ir_ctrl;
  localparam int W = 32;
  localparam int CW = 4;
  localparam logic [31:0] LUI = 32'h3C010001, LW = 32'h8C220000, BEQ = 32'h10410002, ADDIU = 32'h24010005;

  logic          clk = 1'b0, reset = 1'b0, stop = 1'b0;
  logic [W-1:0]  instr_f = '0, npc, pc_f;
  logic [W-1:0]  ir_d, ir_e, ir_m, ir_w, pc_d, pc_e, pc_m, pc_w;
  logic [CW-1:0] stall_cnt, retire_cnt;
  logic          stall_err;
  int            n_assert = 0, n_fail = 0;

  pipe_ir_ctrl #(.WIDTH(W), .CNT_W(CW), .MAX_STALL(2), .PC_RST(32'h00003000)) dut (
    .clk(clk), .reset(reset), .stop(stop), .instr_f(instr_f), .npc(npc), .pc_f(pc_f),
    .IR_D(ir_d), .IR_E(ir_e), .IR_M(ir_m), .IR_W(ir_w),
    .PC_D(pc_d), .PC_E(pc_e), .PC_M(pc_m), .PC_W(pc_w),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt), .stall_err(stall_err)
  );

  assign npc = pc_f + 32'd4;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held low
    tick(2);
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_ir_d", ir_d, 0);
    chk("rst_ir_e", ir_e, 0);
    chk("rst_ir_m", ir_m, 0);
    chk("rst_ir_w", ir_w, 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_err", 32'(stall_err), 0);
    // release: lui at 0x3000 walks to W
    reset = 1'b1; instr_f = LUI;
    tick(1);
    chk("e1_ir_d", ir_d, LUI);
    chk("e1_pc_d", pc_d, 32'h3000);
    chk("e1_pc_f", pc_f, 32'h3004);
    instr_f = 0;
    tick(3);
    chk("e4_ir_w", ir_w, LUI);
    chk("e4_pc_w", pc_w, 32'h3000);
    chk("e4_retire", 32'(retire_cnt), 1);
    chk("e4_pc_f", pc_f, 32'h3010);
    // single stall with lw in D
    instr_f = LW;
    tick(1);
    chk("e5_ir_d", ir_d, LW);
    stop = 1'b1; instr_f = BEQ;
    tick(1);
    chk("s1_ir_d", ir_d, LW);
    chk("s1_pc_d", pc_d, 32'h3010);
    chk("s1_ir_e", ir_e, 0);
    chk("s1_pc_f", pc_f, 32'h3014);
    chk("s1_stall", 32'(stall_cnt), 1);
    stop = 1'b0;
    tick(1);
    chk("s1_ir_e_lw", ir_e, LW);
    chk("s1_pc_e_lw", pc_e, 32'h3010);
    chk("s1_ir_d_beq", ir_d, BEQ);
    // two-cycle stall: beq frozen in D, lw proceeds
    instr_f = 0; stop = 1'b1;
    tick(1);
    chk("s2a_pc_d", pc_d, 32'h3014);
    chk("s2a_ir_m", ir_m, LW);
    chk("s2a_ir_e", ir_e, 0);
    tick(1);
    chk("s2b_pc_d", pc_d, 32'h3014);
    chk("s2b_ir_d", ir_d, BEQ);
    chk("s2b_ir_m", ir_m, 0);
    chk("s2b_ir_w", ir_w, LW);
    chk("s2b_stall", 32'(stall_cnt), 3);
    chk("s2b_err", 32'(stall_err), 0);
    chk("s2b_retire", 32'(retire_cnt), 2);
    stop = 1'b0;
    tick(1);
    chk("s2c_ir_e", ir_e, BEQ);
    chk("s2c_ir_w", ir_w, 0);
    tick(1);
    chk("s2d_ir_w", ir_w, 0);
    chk("s2d_retire", 32'(retire_cnt), 2);
    // watchdog: three consecutive stalls
    stop = 1'b1;
    tick(2);
    chk("wd2_err", 32'(stall_err), 0);
    tick(1);
    chk("wd3_err", 32'(stall_err), 1);
    chk("wd3_stall", 32'(stall_cnt), 6);
    stop = 1'b0;
    tick(1);
    chk("wd_sticky", 32'(stall_err), 1);
    // async reset between edges while stalling
    stop = 1'b1;
    tick(1);
    chk("ar_pre_stall", 32'(stall_cnt), 7);
    #2 reset = 1'b0;
    #1;
    chk("ar_pc_f", pc_f, 32'h3000);
    chk("ar_stall", 32'(stall_cnt), 0);
    chk("ar_err", 32'(stall_err), 0);
    chk("ar_ir_d", ir_d, 0);
    chk("ar_ir_w", ir_w, 0);
    chk("ar_retire", 32'(retire_cnt), 0);
    tick(1);
    reset = 1'b1; stop = 1'b0; instr_f = ADDIU;
    tick(1);
    chk("ar_post_ir_d", ir_d, ADDIU);
    chk("ar_post_pc_d", pc_d, 32'h3000);
    chk("ar_post_pc_f", pc_f, 32'h3004);
    // stall counter saturation
    stop = 1'b1;
    tick(14);
    chk("sat_stall14", 32'(stall_cnt), 14);
    tick(1);
    chk("sat_stall15", 32'(stall_cnt), 15);
    tick(5);
    chk("sat_stall20", 32'(stall_cnt), 15);
    chk("sat_stall_retire", 32'(retire_cnt), 0);
    // retire counter saturation
    stop = 1'b0; reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(10);
    chk("sat_ret7", 32'(retire_cnt), 7);
    tick(15);
    chk("sat_ret15", 32'(retire_cnt), 15);
    chk("sat_ret_stall", 32'(stall_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
